blink_period_meter: RTL and testbench

Receive-side companion to the programmable blinker: watches a single blinking waveform and recovers its timing. Measures the period (cycles between rising edges) and the high time of each cycle, then reports both with a one-cycle valid strobe and a floor-log2 estimate of the period. Used on the board to read back the rate a blinker was shifted to, and in benches as a self-checking monitor on a blinker's `out`.

---
 rtl/blink_period_meter.sv | 135 +++++++++++++
 tb/tb_blink_period_meter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_period_meter.sv
// Measures period, high time and floor-log2 of the period of a blinking input.
// Optional `BLINK_METER_SYNC_EN` adds a 2-flop input synchronizer (+1 cycle latency).
module blink_period_meter #(
  parameter int WIDTH   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               blink_in,
  output logic [WIDTH-1:0]   period,
  output logic [WIDTH-1:0]   high_time,
  output logic [SHIFT_W-1:0] shift_est,
  output logic               valid,
  output logic               timeout
);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t               state, state_nxt;
  logic                 s, s_prev, s_live, seen_low, rise;
  logic [WIDTH-1:0]     cnt, cnt_nxt, hcnt, hcnt_nxt, cnt_inc;
  logic [WIDTH-1:0]     period_nxt, high_nxt;
  logic [SHIFT_W-1:0]   shift_nxt;
  logic                 valid_nxt, timeout_nxt;

  // s_live marks that s holds a real post-reset sample, not a reset value.
`ifdef BLINK_METER_SYNC_EN
  logic sync_0, live_0;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_0 <= 1'b0;
      live_0 <= 1'b0;
      s      <= 1'b0;
      s_live <= 1'b0;
    end else begin
      sync_0 <= blink_in;
      live_0 <= 1'b1;
      s      <= sync_0;
      s_live <= live_0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      s      <= 1'b0;
      s_live <= 1'b0;
    end else begin
      s      <= blink_in;
      s_live <= 1'b1;
    end
  end
`endif

  // A level held high across reset release must be seen low before it can rise.
  assign rise    = s & ~s_prev & seen_low;
  assign cnt_inc = cnt + ONE;

  function automatic logic [SHIFT_W-1:0] floor_log2(input logic [WIDTH-1:0] v);
    floor_log2 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) floor_log2 = SHIFT_W'(i);
    end
  endfunction

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hcnt_nxt    = hcnt;
    period_nxt  = period;
    high_nxt    = high_time;
    shift_nxt   = shift_est;
    valid_nxt   = 1'b0;
    timeout_nxt = timeout;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        hcnt_nxt = '0;
        if (rise) begin
          state_nxt = MEASURE;
          hcnt_nxt  = ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_nxt  = cnt_inc;
          high_nxt    = hcnt;
          shift_nxt   = floor_log2(cnt_inc);
          valid_nxt   = 1'b1;
          timeout_nxt = 1'b0;
          cnt_nxt     = '0;
          hcnt_nxt    = ONE;
        end else if (cnt == CNT_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          hcnt_nxt    = '0;
        end else begin
          cnt_nxt  = cnt_inc;
          hcnt_nxt = hcnt + {{(WIDTH-1){1'b0}}, s};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s_prev    <= 1'b0;
      seen_low  <= 1'b0;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      shift_est <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_prev    <= s;
      seen_low  <= seen_low | (s_live & ~s);
      cnt       <= cnt_nxt;
      hcnt      <= hcnt_nxt;
      period    <= period_nxt;
      high_time <= high_nxt;
      shift_est <= shift_nxt;
      valid     <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_blink_period_meter.sv
// Bench for blink_period_meter (WIDTH=8) against a rise-to-rise model of the input stream.
module tb_blink_period_meter;
  localparam int W  = 8;
  localparam int SW = 3;
  localparam int MAX_P = (1 << W) - 1;
`ifdef BLINK_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          blink_in = 1'b0;
  logic [W-1:0]  period, high_time;
  logic [SW-1:0] shift_est;
  logic          valid, timeout;

  blink_period_meter #(.WIDTH(W), .SHIFT_W(SW)) dut (
    .clk(clk), .rst(rst), .blink_in(blink_in),
    .period(period), .high_time(high_time), .shift_est(shift_est),
    .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    bit is_to;
    int p;
    int h;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int total = 0, bad = 0, cyc = 0;
  int exp_valid_cnt = 0, seen_valid_cnt = 0;
  bit have_prev = 0, prev_b = 0, armed = 0, rise;
  int last_rise = 0, highs = 0;
  logic          exp_valid = 0, exp_to = 0;
  logic [W-1:0]  exp_p = 0, exp_h = 0;
  logic [SW-1:0] exp_sh = 0;

  function automatic int flog2(input int v);
    int r = 0;
    while (v > 1) begin
      v = v >> 1;
      r++;
    end
    return r;
  endfunction

  // Reference model: measurements are defined on the sampled input stream itself.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      have_prev = 0; armed = 0;
      exp_valid = 0; exp_to = 0; exp_p = 0; exp_h = 0; exp_sh = 0;
    end else begin
      rise = have_prev && !prev_b && (blink_in === 1'b1);
      if (armed) begin
        if (rise) begin
          ev.due = cyc + LAT; ev.is_to = 0; ev.p = cyc - last_rise; ev.h = highs;
          exp_q.push_back(ev);
          last_rise = cyc; highs = 1;
        end else if (cyc - last_rise == MAX_P) begin
          ev.due = cyc + LAT; ev.is_to = 1; ev.p = 0; ev.h = 0;
          exp_q.push_back(ev);
          armed = 0;
        end else begin
          highs += (blink_in === 1'b1) ? 1 : 0;
        end
      end else if (rise) begin
        armed = 1; last_rise = cyc; highs = 1;
      end
      prev_b = (blink_in === 1'b1);
      have_prev = 1;
      exp_valid = 0;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        ev = exp_q.pop_front();
        if (ev.is_to) exp_to = 1;
        else begin
          exp_valid = 1; exp_to = 0;
          exp_p = W'(ev.p); exp_h = W'(ev.h); exp_sh = SW'(flog2(ev.p));
          exp_valid_cnt++;
        end
      end
    end
  end

  // Scoreboard: every output compared against the model each cycle.
  initial forever begin
    @(negedge clk);
    if (valid === 1'b1) seen_valid_cnt++;
    total++;
    if (valid !== exp_valid) begin
      bad++; $display("FAIL mon_valid cyc=%0d got=%b exp=%b", cyc, valid, exp_valid);
    end
    total++;
    if (timeout !== exp_to) begin
      bad++; $display("FAIL mon_timeout cyc=%0d got=%b exp=%b", cyc, timeout, exp_to);
    end
    total++;
    if (period !== exp_p || high_time !== exp_h || shift_est !== exp_sh) begin
      bad++;
      $display("FAIL mon_values cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
               cyc, period, high_time, shift_est, exp_p, exp_h, exp_sh);
    end
  end

  task automatic drive(input logic b, input logic r);
    @(negedge clk);
    blink_in = b;
    rst = r;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    repeat (n) begin
      repeat (hi) drive(1'b1, 1'b0);
      repeat (lo) drive(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) drive(i[0], 1'b1);
    drive(1'b1, 1'b0);
    total++;
    if (period !== 0 || high_time !== 0 || shift_est !== 0 || valid !== 0 || timeout !== 0) begin
      bad++; $display("FAIL reset_outputs got=%0d/%0d/%0d/%b/%b exp=0/0/0/0/0",
                      period, high_time, shift_est, valid, timeout);
    end
    for (int i = 0; i < 2; i++) begin
      drive(i == 0 ? 1'b1 : 1'b0, 1'b0);
      total++;
      if (valid !== 1'b0) begin
        bad++; $display("FAIL reset_no_valid i=%0d got=%b exp=0", i, valid);
      end
    end
  endtask

  task automatic test_square;
    repeat (2) drive(1'b0, 1'b0);
    wave(1, 1, 20);
    repeat (3) drive(1'b0, 1'b0);
    total++;
    if (period !== 2 || high_time !== 1 || shift_est !== 1 || timeout !== 0) begin
      bad++; $display("FAIL square_2_1_1 got=%0d/%0d/%0d to=%b exp=2/1/1 to=0",
                      period, high_time, shift_est, timeout);
    end
  endtask

  task automatic test_mixed;
    wave(3, 5, 6);
    total++;
    if (period !== 8 || high_time !== 3 || shift_est !== 3) begin
      bad++; $display("FAIL mixed_8_3_3 got=%0d/%0d/%0d exp=8/3/3", period, high_time, shift_est);
    end
    wave(12, 12, 4);
    repeat (LAT + 1) drive(1'b0, 1'b0);
    total++;
    if (period !== 24 || high_time !== 12 || shift_est !== 4) begin
      bad++; $display("FAIL mixed_24_12_4 got=%0d/%0d/%0d exp=24/12/4", period, high_time, shift_est);
    end
  endtask

  task automatic test_timeout;
    drive(1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);
    wave(4, 4, 2);
    repeat (300) drive(1'b0, 1'b0);
    total++;
    if (timeout !== 1'b1 || period !== 8 || high_time !== 4 || shift_est !== 3) begin
      bad++; $display("FAIL timeout_set got=to%b %0d/%0d/%0d exp=to1 8/4/3",
                      timeout, period, high_time, shift_est);
    end
    wave(4, 4, 1);
    total++;
    if (timeout !== 1'b1) begin
      bad++; $display("FAIL timeout_first_rise_silent got=%b exp=1", timeout);
    end
    repeat (4) drive(1'b1, 1'b0);
    total++;
    if (timeout !== 1'b0 || period !== 8 || high_time !== 4 || shift_est !== 3) begin
      bad++; $display("FAIL timeout_cleared got=to%b %0d/%0d/%0d exp=to0 8/4/3",
                      timeout, period, high_time, shift_est);
    end
    repeat (4) drive(1'b0, 1'b0);
  endtask

  task automatic test_boundary;
    drive(1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (254) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (254) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0);
    total++;
    if (period !== 255 || high_time !== 1 || shift_est !== 7 || timeout !== 0) begin
      bad++; $display("FAIL boundary_max_period got=%0d/%0d/%0d to=%b exp=255/1/7 to=0",
                      period, high_time, shift_est, timeout);
    end
    repeat (255) drive(1'b0, 1'b0);
    total++;
    if (timeout !== 1'b1 || period !== 255) begin
      bad++; $display("FAIL boundary_timeout got=to%b p=%0d exp=to1 p=255", timeout, period);
    end
  endtask

  task automatic test_reset_mid;
    repeat (2) drive(1'b0, 1'b0);
    wave(3, 3, 2);
    drive(1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    total++;
    if (period !== 0 || high_time !== 0 || shift_est !== 0 || valid !== 0 || timeout !== 0) begin
      bad++; $display("FAIL reset_mid_cleared got=%0d/%0d/%0d/%b/%b exp=0/0/0/0/0",
                      period, high_time, shift_est, valid, timeout);
    end
    wave(3, 3, 1);
    repeat (3) drive(1'b0, 1'b0);
    total++;
    if (period !== 0) begin
      bad++; $display("FAIL reset_mid_one_rise got=%0d exp=0", period);
    end
    wave(3, 3, 1);
    repeat (3) drive(1'b0, 1'b0);
    total++;
    if (period !== 9 || high_time !== 3 || shift_est !== 3) begin
      bad++; $display("FAIL reset_mid_two_rises got=%0d/%0d/%0d exp=9/3/3", period, high_time, shift_est);
    end
  endtask

  task automatic test_random;
    int v0, s0;
    v0 = exp_valid_cnt;
    s0 = seen_valid_cnt;
    for (int i = 0; i < 40; i++) begin
      int hi, lo;
      hi = $urandom_range(1, 12);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(240, 270) : $urandom_range(1, 12);
      wave(hi, lo, 1);
    end
    repeat (LAT + 1) drive(1'b0, 1'b0);
    total++;
    if ((seen_valid_cnt - s0) !== (exp_valid_cnt - v0)) begin
      bad++; $display("FAIL random_valid_count got=%0d exp=%0d",
                      seen_valid_cnt - s0, exp_valid_cnt - v0);
    end
  endtask

  initial begin
    test_reset;
    test_square;
    test_mixed;
    test_timeout;
    test_boundary;
    test_reset_mid;
    test_random;
    repeat (2) drive(1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
